// File: rtl/conv_ctrl_slave.sv
// rtl/conv_ctrl_slave.sv - Avalon-MM control/status slave for the convolution engine
//
// Purpose: lets the host program the convolution engine configuration, launch a
// job with a one-cycle request, track completion via the engine acknowledge, and
// report busy/done/error/timeout status, job count, per-job latency and a level irq.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   avs_address[2:0]         word address
//   avs_read, avs_write      access strobes
//   avs_writedata[31:0]      write data
//   avs_readdata[31:0]       read data, one cycle after avs_read, 0 otherwise
//   irq_o                    DONE & IRQ_EN
//   Share_o .. AccuEn_o      engine configuration, straight from the CFG registers
//   Req_o                    one-cycle job request
//   Ack_i                    one-cycle job completion from the engine
module conv_ctrl_slave #(
    parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq_o,
    output logic        Share_o,
    output logic [2:0]  ConvSize_o,
    output logic [3:0]  DataBp_o,
    output logic [3:0]  WeightBp_o,
    output logic [3:0]  ResultBp_o,
    output logic [8:0]  Height_o,
    output logic [3:0]  CoreEnable_o,
    output logic        AccuEn_o,
    output logic        Req_o,
    input  logic        Ack_i
);

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrCfg0   = 3'd1;
    localparam logic [2:0] AddrCfg1   = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
    localparam logic [2:0] AddrJobCnt = 3'd4;
    localparam logic [2:0] AddrCycles = 3'd5;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_t;

    state_t      state;
    logic        irqEn;
    logic        done;
    logic        err;
    logic        timeout;
    logic [15:0] jobCnt;
    logic [31:0] cycleCnt;
    logic [31:0] lastCycles;

    logic        busy;
    logic        wrCtrl;
    logic        wrCfg0;
    logic        wrCfg1;
    logic        wrStatus;
    logic        startReq;
    logic        startOk;
    logic        startRej;
    logic        cfgRej;
    logic        ackHit;
    logic        timeoutHit;
    logic [31:0] cycleCntNext;
    logic [31:0] cfg0Word;
    logic [31:0] statusWord;
    logic [31:0] readMux;

    always_comb begin
        busy     = (state == StBusy);
        wrCtrl   = avs_write && (avs_address == AddrCtrl);
        wrCfg0   = avs_write && (avs_address == AddrCfg0);
        wrCfg1   = avs_write && (avs_address == AddrCfg1);
        wrStatus = avs_write && (avs_address == AddrStatus);
        startReq = wrCtrl && avs_writedata[0];
        // Without core 0 enabled the engine never acknowledges, so refuse to start.
        startOk  = startReq && !busy && CoreEnable_o[0];
        startRej = startReq && (busy || !CoreEnable_o[0]);
        cfgRej   = (wrCfg0 || wrCfg1) && busy;
        ackHit   = busy && Ack_i;

        // Counter reads 1 in the request cycle and saturates at all-ones.
        cycleCntNext = cycleCnt;
        if (startOk) begin
            cycleCntNext = 32'd1;
        end else if (busy && (cycleCnt != 32'hFFFF_FFFF)) begin
            cycleCntNext = cycleCnt + 32'd1;
        end
        // Flag in the same cycle the counter shows the threshold value.
        timeoutHit = (TimeoutCycles != 32'd0) && (startOk || busy)
                     && (cycleCntNext == TimeoutCycles);

        cfg0Word   = {8'd0, CoreEnable_o, 3'd0, AccuEn_o, ResultBp_o,
                      WeightBp_o, DataBp_o, ConvSize_o, Share_o};
        statusWord = {28'd0, timeout, err, done, busy};

        readMux = 32'd0;
        case (avs_address)
            AddrCtrl:   readMux = {30'd0, irqEn, 1'b0};
            AddrCfg0:   readMux = cfg0Word;
            AddrCfg1:   readMux = {23'd0, Height_o};
            AddrStatus: readMux = statusWord;
            AddrJobCnt: readMux = {16'd0, jobCnt};
            AddrCycles: readMux = lastCycles;
            default:    readMux = 32'd0;
        endcase
    end

    assign irq_o = done && irqEn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            irqEn        <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            jobCnt       <= 16'd0;
            cycleCnt     <= 32'd0;
            lastCycles   <= 32'd0;
            avs_readdata <= 32'd0;
            Share_o      <= 1'b0;
            ConvSize_o   <= 3'd0;
            DataBp_o     <= 4'd0;
            WeightBp_o   <= 4'd0;
            ResultBp_o   <= 4'd0;
            Height_o     <= 9'd0;
            CoreEnable_o <= 4'd0;
            AccuEn_o     <= 1'b0;
            Req_o        <= 1'b0;
        end else begin
            avs_readdata <= avs_read ? readMux : 32'd0;
            Req_o        <= startOk;
            cycleCnt     <= cycleCntNext;

            // A rejected CTRL write leaves IRQ_EN untouched as well.
            if (wrCtrl && !startRej) begin
                irqEn <= avs_writedata[1];
            end

            if (wrCfg0 && !busy) begin
                Share_o      <= avs_writedata[0];
                ConvSize_o   <= avs_writedata[3:1];
                DataBp_o     <= avs_writedata[7:4];
                WeightBp_o   <= avs_writedata[11:8];
                ResultBp_o   <= avs_writedata[15:12];
                AccuEn_o     <= avs_writedata[16];
                CoreEnable_o <= avs_writedata[23:20];
            end
            if (wrCfg1 && !busy) begin
                Height_o <= avs_writedata[8:0];
            end

            case (state)
                StIdle: begin
                    if (startOk) begin
                        state <= StBusy;
                    end
                end
                StBusy: begin
                    if (Ack_i) begin
                        state      <= StIdle;
                        jobCnt     <= jobCnt + 16'd1;
                        lastCycles <= cycleCnt;
                    end
                end
                default: state <= StIdle;
            endcase

            // Set beats W1C clear on every status bit.
            if (ackHit) begin
                done <= 1'b1;
            end else if (startOk || (wrStatus && avs_writedata[1])) begin
                done <= 1'b0;
            end

            if (startRej || cfgRej) begin
                err <= 1'b1;
            end else if (wrStatus && avs_writedata[2]) begin
                err <= 1'b0;
            end

            if (timeoutHit) begin
                timeout <= 1'b1;
            end else if (startOk || (wrStatus && avs_writedata[3])) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_ctrl_slave.sv
// tb/tb_conv_ctrl_slave.sv - scoreboard testbench for conv_ctrl_slave
module tb_conv_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        rd0, wr0, ack0, rd1, wr1, ack1;
    logic [31:0] rdData0, rdData1;
    logic        irq0, irq1;
    logic        share0, share1, accuEn0, accuEn1, req0, req1;
    logic [2:0]  convSize0, convSize1;
    logic [3:0]  dataBp0, dataBp1, weightBp0, weightBp1, resultBp0, resultBp1;
    logic [3:0]  coreEn0, coreEn1;
    logic [8:0]  height0, height1;

    int errors = 0;
    int checks = 0;
    int reqCnt = 0;
    int reqExp = 0;
    logic tgt = 1'b0;
    logic rdV = 1'b0;
    logic rdSel = 1'b0;
    logic [31:0] expQ[$];
    string nameQ[$];

    always #5 clk = ~clk;

    conv_ctrl_slave dut0 (
        .clk(clk), .rst(rst), .avs_address(addr), .avs_read(rd0), .avs_write(wr0),
        .avs_writedata(wdata), .avs_readdata(rdData0), .irq_o(irq0),
        .Share_o(share0), .ConvSize_o(convSize0), .DataBp_o(dataBp0),
        .WeightBp_o(weightBp0), .ResultBp_o(resultBp0), .Height_o(height0),
        .CoreEnable_o(coreEn0), .AccuEn_o(accuEn0), .Req_o(req0), .Ack_i(ack0)
    );

    conv_ctrl_slave #(.TimeoutCycles(32'd8)) dut1 (
        .clk(clk), .rst(rst), .avs_address(addr), .avs_read(rd1), .avs_write(wr1),
        .avs_writedata(wdata), .avs_readdata(rdData1), .irq_o(irq1),
        .Share_o(share1), .ConvSize_o(convSize1), .DataBp_o(dataBp1),
        .WeightBp_o(weightBp1), .ResultBp_o(resultBp1), .Height_o(height1),
        .CoreEnable_o(coreEn1), .AccuEn_o(accuEn1), .Req_o(req1), .Ack_i(ack1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per read response; idle cycles must read 0.
    always @(posedge clk) begin
        rdV   <= rd0 | rd1;
        rdSel <= rd1;
    end

    always @(negedge clk) begin
        if (req0) reqCnt <= reqCnt + 1;
        if (rdV) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected read response");
            end else begin
                chk(nameQ.pop_front(), rdSel ? rdData1 : rdData0, expQ.pop_front());
            end
        end else begin
            chk("idleRead0", rdData0, 32'd0);
            chk("idleRead1", rdData1, 32'd0);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d;
        if (tgt) wr1 = 1'b1; else wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0; wr1 = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        addr = a;
        expQ.push_back(e);
        nameQ.push_back(n);
        if (tgt) rd1 = 1'b1; else rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic ack();
        if (tgt) ack1 = 1'b1; else ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0; ack1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chkReq(input string n);
        #1;
        chk(n, reqCnt, reqExp);
    endtask

    initial begin
        rst = 1'b1; addr = 3'd0; wdata = 32'd0;
        rd0 = 0; wr0 = 0; ack0 = 0; rd1 = 0; wr1 = 0; ack1 = 0;
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rstOut", {share0, convSize0, dataBp0, weightBp0, resultBp0, height0,
                       coreEn0, accuEn0, req0, irq0}, 32'd0);
        for (int i = 0; i < 8; i++) rd(i[2:0], 32'd0, "rstReg");

        // Basic job: Ack 20 cycles after Req_o
        wr(3'd1, 32'h0010_3345);
        wr(3'd2, 32'h0000_0040);
        wr(3'd0, 32'h0000_0003);
        chk("reqPulse", {31'd0, req0}, 32'd1);
        reqExp = 1;
        idle(20);
        ack();
        chk("irqSet", {31'd0, irq0}, 32'd1);
        chkReq("reqCnt1");
        chk("cfgOut", {share0, convSize0, dataBp0, weightBp0, resultBp0, accuEn0, coreEn0},
            {1'b1, 3'd2, 4'd4, 4'd3, 4'd3, 1'b0, 4'd1});
        chk("heightOut", {23'd0, height0}, 32'h40);
        rd(3'd3, 32'h2, "status1");
        rd(3'd5, 32'd21, "cycles1");
        rd(3'd4, 32'd1, "jobcnt1");
        rd(3'd1, 32'h0010_3345, "cfg0Rb");
        rd(3'd0, 32'h2, "ctrlRb");
        wr(3'd3, 32'h2);
        chk("irqClr", {31'd0, irq0}, 32'd0);
        rd(3'd3, 32'h0, "status1Clr");

        // CoreEnable[0]=0: start refused
        wr(3'd1, 32'h0000_3345);
        wr(3'd0, 32'h0000_0003);
        chkReq("noReqCore0");
        rd(3'd3, 32'h4, "statusErrCore");
        wr(3'd3, 32'h4);
        rd(3'd3, 32'h0, "statusErrClr");

        // Rejected accesses while busy
        wr(3'd1, 32'h0010_3345);
        wr(3'd0, 32'h0000_0003);
        reqExp++;
        wr(3'd0, 32'h0000_0003);
        wr(3'd2, 32'h0000_01FF);
        chkReq("noSecondReq");
        chk("heightHeld", {23'd0, height0}, 32'h40);
        rd(3'd3, 32'h5, "statusBusyErr");
        ack();
        rd(3'd3, 32'h6, "statusDoneErr");
        rd(3'd4, 32'd2, "jobcnt2");
        rd(3'd2, 32'h40, "cfg1Held");
        wr(3'd3, 32'h6);
        rd(3'd6, 32'd0, "addr6");

        // Ack coincident with W1C DONE, in the request cycle
        wr(3'd0, 32'h0000_0003);
        reqExp++;
        addr = 3'd3; wdata = 32'h2; wr0 = 1'b1; ack0 = 1'b1;
        idle(1);
        wr0 = 1'b0; ack0 = 1'b0;
        rd(3'd3, 32'h2, "doneSetWins");
        rd(3'd5, 32'd1, "cycles1cyc");
        ack();
        rd(3'd4, 32'd3, "spuriousAck");
        // START coincident with Ack: rejected
        wr(3'd0, 32'h0000_0003);
        reqExp++;
        idle(2);
        addr = 3'd0; wdata = 32'h3; wr0 = 1'b1; ack0 = 1'b1;
        idle(1);
        wr0 = 1'b0; ack0 = 1'b0;
        chkReq("startAckReq");
        rd(3'd3, 32'h6, "startAckStatus");
        rd(3'd4, 32'd4, "jobcnt4");
        rd(3'd5, 32'd3, "cycles3");

        // Timeout instance (threshold 8)
        tgt = 1'b1;
        wr(3'd1, 32'h0010_0000);
        wr(3'd0, 32'h0000_0001);
        idle(6);
        rd(3'd3, 32'h1, "toBefore");
        rd(3'd3, 32'h9, "toAt8");
        ack();
        rd(3'd3, 32'hA, "toDone");
        rd(3'd5, 32'd9, "toCycles");
        tgt = 1'b0;

        // Reset mid-job
        wr(3'd0, 32'h0000_0001);
        reqExp++;
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rstMidOut", {share0, convSize0, dataBp0, weightBp0, resultBp0, height0,
                          coreEn0, accuEn0, req0, irq0}, 32'd0);
        rd(3'd3, 32'h0, "rstStatus");
        rd(3'd4, 32'h0, "rstJobcnt");
        rd(3'd5, 32'h0, "rstCycles");
        ack();
        rd(3'd3, 32'h0, "lateAckStatus");
        rd(3'd4, 32'h0, "lateAckJobcnt");
        wr(3'd1, 32'h0010_0000);
        wr(3'd0, 32'h0000_0001);
        chk("reqAfterRst", {31'd0, req0}, 32'd1);
        reqExp++;
        chkReq("reqCntFinal");
        ack();
        rd(3'd3, 32'h2, "postRstDone");
        rd(3'd4, 32'd1, "postRstJobcnt");

        idle(2);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboardDrain: %0d responses outstanding, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
